// File: rtl/icosoc_triggerrec_packer.sv
// Packs 64-bit trigger-recorder events into a delta-timestamp-coded 32-bit stream:
// short form (one word) when the delta fits, otherwise long form (two words, absolute ts).
module icosoc_triggerrec_packer #(
  parameter int unsigned DELTA_BITS  = 15,
  parameter int unsigned RESYNC_EVTS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  input  logic        resync,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic [31:0] stat_evts,
  output logic [31:0] stat_long
);

  localparam int unsigned TS_W  = 47;
  localparam int unsigned IO_W  = 16;
  localparam int unsigned CNT_W = $clog2(RESYNC_EVTS) + 1;

  typedef enum logic {
    IDLE,
    LONG2
  } state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [31:0]       word1_q, word1_d;
  logic [TS_W-1:0]   prev_ts_q, prev_ts_d;
  logic              force_long_q, force_long_d;
  logic [CNT_W-1:0]  resync_cnt_q, resync_cnt_d;
  logic [31:0]       stat_evts_q, stat_evts_d;
  logic [31:0]       stat_long_q, stat_long_d;

  logic [TS_W-1:0]   ts;
  logic [IO_W-1:0]   io;
  logic [TS_W-1:0]   delta;
  logic              short_ok;
  logic              in_ready_c;
  logic              consume;
  logic              unused_flag;

  assign ts          = in_data[TS_W-1:0];
  assign io          = in_data[63:48];
  assign unused_flag = in_data[47];
  assign delta       = ts - prev_ts_q;

  // A backwards timestamp or an oversize delta can only be carried in long form.
  assign short_ok = !force_long_q
                 && (resync_cnt_q < CNT_W'(RESYNC_EVTS - 1))
                 && (ts >= prev_ts_q)
                 && (delta[TS_W-1:DELTA_BITS] == '0);

  assign in_ready_c = !reset && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign consume    = in_valid && in_ready_c;

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign stat_evts = stat_evts_q;
  assign stat_long = stat_long_q;

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    word1_d      = word1_q;
    prev_ts_d    = prev_ts_q;
    force_long_d = force_long_q;
    resync_cnt_d = resync_cnt_q;
    stat_evts_d  = stat_evts_q;
    stat_long_d  = stat_long_q;

    unique case (state_q)
      IDLE: begin
        if (consume) begin
          out_valid_d  = 1'b1;
          prev_ts_d    = ts;
          stat_evts_d  = stat_evts_q + 32'd1;
          force_long_d = 1'b0;
          if (short_ok) begin
            out_data_d   = {1'b0, delta[DELTA_BITS-1:0], io};
            resync_cnt_d = resync_cnt_q + CNT_W'(1);
          end else begin
            out_data_d   = {1'b1, ts[46:32], io};
            word1_d      = ts[31:0];
            resync_cnt_d = '0;
            stat_long_d  = stat_long_q + 32'd1;
            state_d      = LONG2;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      LONG2: begin
        if (out_valid_q && out_ready) begin
          out_data_d = word1_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A resync arriving with a consume applies to the following event.
    if (resync) begin
      force_long_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      word1_q      <= '0;
      prev_ts_q    <= '0;
      force_long_q <= 1'b1;
      resync_cnt_q <= '0;
      stat_evts_q  <= '0;
      stat_long_q  <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      word1_q      <= word1_d;
      prev_ts_q    <= prev_ts_d;
      force_long_q <= force_long_d;
      resync_cnt_q <= resync_cnt_d;
      stat_evts_q  <= stat_evts_d;
      stat_long_q  <= stat_long_d;
    end
  end

endmodule
